sd_dma_rx_fifo_gen: RTL

Parametrised next-generation SD RX buffer between the SD data receive path (narrow, un-throttleable writes) and the MIC DMA write engine (wide, chunk-burst reads).
- Packs 2^RATIO_L2 datapath beats into one DMA word.
- Releases data to DMA a whole chunk at a time.
- New over the previous generation: an explicit flush that pads and commits a partial word or chunk, so a short block tail can drain.
- Also adds a committed-word count for DMA burst sizing, a registered read-data valid, and a sticky overflow flag.

---
 rtl/sd_dma_rx_fifo_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sd_dma_rx_fifo_gen.sv
// sd_dma_rx_fifo_gen: SD RX buffer packing DP beats into DMA words, released to DMA a chunk at a time, with flush.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   dp_ptr_reset      clears write pointer, lane index, commit pointer, flush FSM and overflow flag
//   dp_write_strobe   one beat on dp_wdata this cycle
//   dp_flush          pad and commit everything written so far; dp_flush_busy while in progress
//   dp_full           no free word slot; dp_overflow is sticky after a dropped beat
//   dma_ptr_reset     clears read pointer
//   dma_read_strobe   read next committed word when dma_can_read
//   dma_rdata         read data, updated one cycle after an accepted read with dma_rdata_valid
//   dma_words_avail   committed unread words; dma_chunk_ready when at least one chunk is available
module sd_dma_rx_fifo_gen #(
    parameter int DP_W          = 32,
    parameter int RATIO_L2      = 1,
    parameter int CHUNK_L2      = 3,
    parameter int NUM_CHUNKS_L2 = 2,
    parameter int FIFO_L2       = CHUNK_L2 + NUM_CHUNKS_L2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dp_ptr_reset,
    input  logic                    dp_write_strobe,
    input  logic [DP_W-1:0]         dp_wdata,
    input  logic                    dp_flush,
    output logic                    dp_flush_busy,
    output logic                    dp_full,
    output logic                    dp_overflow,
    input  logic                    dma_ptr_reset,
    input  logic                    dma_read_strobe,
    output logic                    dma_can_read,
    output logic [(DP_W << RATIO_L2)-1:0] dma_rdata,
    output logic                    dma_rdata_valid,
    output logic [FIFO_L2:0]        dma_words_avail,
    output logic                    dma_chunk_ready
);
    localparam int DMA_W = DP_W << RATIO_L2;
    localparam int RATIO = 1 << RATIO_L2;
    localparam int LW    = RATIO_L2 > 0 ? RATIO_L2 : 1;
    localparam int PW    = FIFO_L2 + 1;
    localparam logic [PW-1:0] DEPTH       = PW'(1) << FIFO_L2;
    localparam logic [PW-1:0] CHUNK_WORDS = PW'(1) << CHUNK_L2;
    localparam logic [PW-1:0] CHUNK_MASK  = CHUNK_WORDS - PW'(1);

    typedef enum logic [1:0] {IDLE, PAD, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [LW-1:0]     lane_q, lane_d, lane_nxt;
    logic [DMA_W-1:0]  stage_q, stage_d;
    logic              ovf_q, ovf_d;
    logic [DMA_W-1:0]  rdata_q;
    logic              rvalid_q;
    logic [DMA_W-1:0]  mem [0:(1 << FIFO_L2)-1];
    logic              accept, last, dp_wr, pad_wr, ram_we, rd;
    logic [DMA_W-1:0]  wword, pad_word, ram_wdata;
    logic [PW-1:0]     wptr_inc;

    assign dp_full         = (wptr_q - rptr_q) == DEPTH;
    assign dp_flush_busy   = state_q != IDLE;
    assign dp_overflow     = ovf_q;
    assign accept          = dp_write_strobe && !dp_full && !dp_flush_busy && !dp_ptr_reset;
    assign last            = lane_q == LW'(RATIO - 1);
    assign dp_wr           = accept && last;
    assign lane_nxt        = accept ? (last ? '0 : lane_q + LW'(1)) : lane_q;
    assign pad_wr          = (state_q == PAD) && !dp_full && !dp_ptr_reset;
    // The RAM is single-ported: any write this cycle blocks the read.
    assign ram_we          = dp_wr || pad_wr;
    assign ram_wdata       = dp_wr ? wword : pad_word;
    assign wptr_inc        = wptr_q + PW'(1);
    assign dma_can_read    = (cptr_q != rptr_q) && !ram_we;
    assign rd              = dma_read_strobe && dma_can_read && !dma_ptr_reset;
    assign dma_words_avail = cptr_q - rptr_q;
    assign dma_chunk_ready = dma_words_avail >= CHUNK_WORDS;
    assign dma_rdata       = rdata_q;
    assign dma_rdata_valid = rvalid_q;

    // wword is the staged word with the current beat dropped into its lane; on the last lane it is the full RAM word.
    always_comb begin
        wword = stage_q;
        wword[DP_W*lane_q +: DP_W] = dp_wdata;
        pad_word = '0;
        for (int i = 0; i < RATIO; i++)
            pad_word[i*DP_W +: DP_W] = (LW'(i) < lane_q) ? stage_q[i*DP_W +: DP_W] : '0;
        stage_d = accept ? wword : stage_q;
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cptr_d  = cptr_q;
        lane_d  = lane_nxt;
        ovf_d   = ovf_q | (dp_write_strobe && !accept);
        rptr_d  = dma_ptr_reset ? '0 : (rd ? rptr_q + PW'(1) : rptr_q);
        if (dp_wr) begin
            wptr_d = wptr_inc;
            if ((wptr_inc & CHUNK_MASK) == '0) cptr_d = wptr_inc;
        end
        case (state_q)
            IDLE:    if (dp_flush) state_d = (lane_nxt != '0) ? PAD : COMMIT;
            PAD:     if (pad_wr) begin
                         wptr_d  = wptr_inc;
                         lane_d  = '0;
                         state_d = COMMIT;
                     end
            COMMIT:  begin
                         cptr_d  = wptr_q;
                         state_d = IDLE;
                     end
            default: state_d = IDLE;
        endcase
        if (dp_ptr_reset) begin
            state_d = IDLE;
            wptr_d  = '0;
            cptr_d  = '0;
            lane_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            cptr_q   <= '0;
            rptr_q   <= '0;
            lane_q   <= '0;
            stage_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            cptr_q   <= cptr_d;
            rptr_q   <= rptr_d;
            lane_q   <= lane_d;
            stage_q  <= stage_d;
            ovf_q    <= ovf_d;
            rvalid_q <= rd;
            if (rd) rdata_q <= mem[rptr_q[FIFO_L2-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[wptr_q[FIFO_L2-1:0]] <= ram_wdata;
    end
endmodule
